riscv_bp_gshare: RTL
====================

RISCV_BP_GSHARE -- requirements
Module: riscv_bp_gshare

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 32, datapath width.
- PC_INIT, 'h200, reset value of the delayed fetch PC.
- HAS_RVC, 0, compressed ISA present.
- BP_INDEX_BITS, 10, table index width; DEPTH = 2**BP_INDEX_BITS.
- BP_GLOBAL_BITS, 8, global history length; SHALL be <= BP_INDEX_BITS.
- BP_CNT_BITS, 2, saturating counter width; SHALL be >= 2.
- BP_PC_LSB, HAS_RVC ? 1 : 2, lowest PC bit used for indexing.
- TECHNOLOGY, "GENERIC", RAM technology selector.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, the single clock.
- rst_i, in, 1, reset; asynchronous and active-high.
- bp_flush_i, in, 1, clear history and re-initialise the table.
- id_stall_i, in, 1, decode stall; freezes the read side.
- if_parcel_pc_i, in, XLEN, fetch PC.
- bp_ready_o, out, 1, table initialised.
- bp_predict_o, out, BP_CNT_BITS, counter read for the fetched parcel.
- bp_taken_o, out, 1, MSB of bp_predict_o.
- bp_history_o, out, BP_GLOBAL_BITS, GHR value used for this prediction.
- ex_pc_i, in, XLEN, resolved branch PC.
- bu_bp_history_i, in, BP_GLOBAL_BITS, history returned with the branch.
- bu_bp_predict_i, in, BP_CNT_BITS, counter value returned with the branch.
- bu_bp_btaken_i, in, 1, branch outcome.
- bu_bp_update_i, in, 1, update strobe.
- bp_mispredict_cnt_o, out, 32, mispredict statistics counter.

Function
REQ-003 Read index SHALL be PCsel[BP_PC_LSB +: BP_INDEX_BITS] XOR {zeros, ghr}, where PCsel = id_stall_i ? pc_dly : if_parcel_pc_i, and pc_dly loads if_parcel_pc_i whenever !id_stall_i.
REQ-004 bp_predict_o and bp_history_o SHALL register one cycle after the read index, and SHALL hold while id_stall_i=1.
REQ-005 Write index SHALL be ex_pc_i[BP_PC_LSB +: BP_INDEX_BITS] XOR {zeros, bu_bp_history_i}.
REQ-006 Update value SHALL be bu_bp_predict_i+1 if taken, bu_bp_predict_i-1 if not taken, saturating at all-ones and at zero.
REQ-007 When an update and a read target the same index in the same cycle, the prediction SHALL return the newly written value (write-first bypass).
REQ-008 GHR SHALL shift {ghr[G-2:0], bu_bp_btaken_i} on every accepted update; it is architectural and is not updated speculatively.
REQ-009 Mispredict is defined as bu_bp_predict_i MSB != bu_bp_btaken_i on an accepted update; bp_mispredict_cnt_o SHALL increment on each mispredict and saturate at 2**32-1.
REQ-010 FSM state INIT: sweep pointer 0..DEPTH-1, one write per cycle of weakly-not-taken (2**(BP_CNT_BITS-1)-1); bp_ready_o=0; bp_predict_o forced to 0; bu_bp_update_i ignored (no table write, no GHR or counter change).
REQ-011 INIT SHALL move to RUN in the cycle after pointer DEPTH-1 is written; bp_ready_o SHALL then read 1.
REQ-012 bp_flush_i in any state SHALL set ghr=0 and pointer=0 and enter INIT; flush during INIT restarts the sweep. The mispredict counter is retained.
REQ-013 An update is accepted only in RUN with bp_flush_i=0.

Reset
REQ-014 On rst_i: state=INIT, pointer=0, ghr=0, pc_dly=PC_INIT, bp_predict_o=0, bp_history_o=0, bp_ready_o=0, bp_mispredict_cnt_o=0.
REQ-015 Reset asserted mid-sweep or in RUN SHALL restart the INIT sweep from 0.

Structure
REQ-016 Package riscv_bp_pkg SHALL hold the FSM state enum and the saturating increment/decrement function.
REQ-017 Counter storage SHALL be the existing rl_ram_1r1w (DBITS=BP_CNT_BITS); its active-low reset is driven by !rst_i. The bypass and init multiplexing live in riscv_bp_gshare.

Verification
REQ-018 Bench parameters: BP_INDEX_BITS=4, BP_GLOBAL_BITS=2, BP_CNT_BITS=2, RVC off. The following scenarios SHALL be covered:
- Release reset -> bp_ready_o=0 for 16 cycles, then 1; every entry reads 2'b01.
- Four updates at PC 'h40, history 0, taken, predict chained from the read -> counter 01->10->11->11 (saturates); bp_taken_o=1.
- Update and read at the same index in the same cycle, predict_i=2'b01, taken -> next-cycle bp_predict_o=2'b10.
- Updates taken, not-taken, taken -> GHR 2'b01, then 2'b10, then 2'b01; bp_history_o matches and the read index flips accordingly.
- predict_i=2'b11, btaken=0, update -> bp_mispredict_cnt_o +1; the same update during INIT -> no change.
- bp_flush_i pulse in RUN -> bp_ready_o low for 16 cycles, GHR=0, counter value retained.

Source files
------------

// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, saturating counter step function.
package riscv_bp_pkg;

  // Table is either being swept to its initial value or serving predictions.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_t;

  // Working width of the saturating step helper; counters up to 8 bits fit.
  localparam int SAT_W = 8;

  // One saturating step toward max (up=1) or toward zero (up=0).
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] cnt,
                                                input logic [SAT_W-1:0] max,
                                                input logic             up);
    logic [SAT_W-1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != max) res = cnt + SAT_W'(1);
    end else begin
      if (cnt != '0) res = cnt - SAT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_bp_gshare_if.sv
// Bundle of fetch-side, branch-unit-side and status signals of the predictor.
// Latency: n/a (signal bundle only).
// Backpressure: id_stall_i freezes the read side; no other flow control.
// Modports: slave = predictor, master = pipeline driving it.
interface riscv_bp_gshare_if #(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 8,
  parameter int BP_CNT_BITS    = 2
);
  logic                      bp_flush_i;
  logic                      id_stall_i;
  logic [XLEN-1:0]           if_parcel_pc_i;
  logic                      bp_ready_o;
  logic [BP_CNT_BITS-1:0]    bp_predict_o;
  logic                      bp_taken_o;
  logic [BP_GLOBAL_BITS-1:0] bp_history_o;
  logic [XLEN-1:0]           ex_pc_i;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i;
  logic [BP_CNT_BITS-1:0]    bu_bp_predict_i;
  logic                      bu_bp_btaken_i;
  logic                      bu_bp_update_i;
  logic [31:0]               bp_mispredict_cnt_o;

  modport slave (
    input  bp_flush_i, id_stall_i, if_parcel_pc_i,
    input  ex_pc_i, bu_bp_history_i, bu_bp_predict_i, bu_bp_btaken_i, bu_bp_update_i,
    output bp_ready_o, bp_predict_o, bp_taken_o, bp_history_o, bp_mispredict_cnt_o
  );

  modport master (
    output bp_flush_i, id_stall_i, if_parcel_pc_i,
    output ex_pc_i, bu_bp_history_i, bu_bp_predict_i, bu_bp_btaken_i, bu_bp_update_i,
    input  bp_ready_o, bp_predict_o, bp_taken_o, bp_history_o, bp_mispredict_cnt_o
  );
endinterface

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid one cycle after raddr_i with re_i=1.
// Backpressure: re_i=0 holds dout_o; no read-during-write bypass inside.
// Ports: rst_ni (async, clears dout_o only), clk_i, waddr_i/din_i/we_i, raddr_i/re_i/dout_o.
module rl_ram_1r1w #(
  parameter int    ABITS      = 10,
  parameter int    DBITS      = 32,
  parameter string TECHNOLOGY = "GENERIC"
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DBITS-1:0] din_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] raddr_i,
  input  logic             re_i,
  output logic [DBITS-1:0] dout_o
);
  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= din_i;
  end

  // Old data is returned when reading the address being written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   dout_o <= '0;
    else if (re_i) dout_o <= mem[raddr_i];
  end
endmodule

// File: rtl/riscv_bp_gshare.sv
// Gshare branch predictor: PC xor global history indexes a table of saturating counters.
// Latency: prediction one cycle after the fetch PC; updates visible next cycle (write-first).
// Backpressure: id_stall_i holds the prediction; updates ignored while the table initialises.
// Ports: clk_i, rst_i (async, active-high), bp (riscv_bp_gshare_if.slave).
module riscv_bp_gshare #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter bit              HAS_RVC        = 1'b0,
  parameter int              BP_INDEX_BITS  = 10,
  parameter int              BP_GLOBAL_BITS = 8,
  parameter int              BP_CNT_BITS    = 2,
  parameter int              BP_PC_LSB      = HAS_RVC ? 1 : 2,
  parameter string           TECHNOLOGY     = "GENERIC"
) (
  input logic           clk_i,
  input logic           rst_i,
  riscv_bp_gshare_if.slave bp
);
  import riscv_bp_pkg::*;

  localparam int DEPTH = 2**BP_INDEX_BITS;
  localparam logic [BP_CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [BP_CNT_BITS-1:0] WEAK_NT = CNT_MAX >> 1;

  typedef logic [BP_INDEX_BITS-1:0] idx_t;

  bp_state_t                 state_q, state_d;
  idx_t                      ptr_q, ptr_d;
  logic [BP_GLOBAL_BITS-1:0] ghr_q, hist_q;
  logic [XLEN-1:0]           pc_dly_q, pc_sel;
  idx_t                      rd_idx, wr_idx, ram_waddr;
  logic [BP_CNT_BITS-1:0]    upd_val, ram_din, ram_dout, byp_val_q, pred, predict;
  logic                      byp_q, ram_we, upd_acc, mispredict, in_init;
  logic [31:0]               mp_cnt_q;
  logic                      unused_pc_bits;

  assign in_init = (state_q == ST_INIT);
  assign upd_acc = !in_init && !bp.bp_flush_i && bp.bu_bp_update_i;

  // Read side: while decode stalls, re-read with the PC that produced the held prediction.
  assign pc_sel = bp.id_stall_i ? pc_dly_q : bp.if_parcel_pc_i;
  assign rd_idx = pc_sel[BP_PC_LSB +: BP_INDEX_BITS] ^ idx_t'(ghr_q);

  // Write side: index with the history the branch was predicted under.
  assign wr_idx     = bp.ex_pc_i[BP_PC_LSB +: BP_INDEX_BITS] ^ idx_t'(bp.bu_bp_history_i);
  assign upd_val    = BP_CNT_BITS'(sat_step(SAT_W'(bp.bu_bp_predict_i), SAT_W'(CNT_MAX),
                                            bp.bu_bp_btaken_i));
  assign mispredict = bp.bu_bp_predict_i[BP_CNT_BITS-1] != bp.bu_bp_btaken_i;

  // The init sweep owns the write port; otherwise accepted updates use it.
  assign ram_we    = in_init || upd_acc;
  assign ram_waddr = in_init ? ptr_q : wr_idx;
  assign ram_din   = in_init ? WEAK_NT : upd_val;

  rl_ram_1r1w #(
    .ABITS      (BP_INDEX_BITS),
    .DBITS      (BP_CNT_BITS),
    .TECHNOLOGY (TECHNOLOGY)
  ) u_ram (
    .rst_ni  (!rst_i),
    .clk_i   (clk_i),
    .waddr_i (ram_waddr),
    .din_i   (ram_din),
    .we_i    (ram_we),
    .raddr_i (rd_idx),
    .re_i    (!bp.id_stall_i),
    .dout_o  (ram_dout)
  );

  // Init / run sequencing.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (bp.bp_flush_i) begin
      state_d = ST_INIT;
      ptr_d   = '0;
    end else if (in_init) begin
      ptr_d = ptr_q + idx_t'(1);
      if (ptr_q == idx_t'(DEPTH-1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Architectural history: advances only on resolved, accepted branches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                ghr_q <= '0;
    else if (bp.bp_flush_i)   ghr_q <= '0;
    else if (upd_acc)         ghr_q <= {ghr_q[BP_GLOBAL_BITS-2:0], bp.bu_bp_btaken_i};
  end

  // Read-side pipeline registers; a same-cycle write to the read index is
  // captured here so the prediction reflects it (the RAM returns old data).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_dly_q  <= PC_INIT;
      hist_q    <= '0;
      byp_q     <= 1'b0;
      byp_val_q <= '0;
    end else if (!bp.id_stall_i) begin
      pc_dly_q  <= bp.if_parcel_pc_i;
      hist_q    <= ghr_q;
      byp_q     <= ram_we && (ram_waddr == rd_idx);
      byp_val_q <= ram_din;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                        mp_cnt_q <= '0;
    else if (upd_acc && mispredict && mp_cnt_q != '1) mp_cnt_q <= mp_cnt_q + 32'd1;
  end

  assign pred    = byp_q ? byp_val_q : ram_dout;
  assign predict = in_init ? '0 : pred;

  assign bp.bp_ready_o          = !in_init;
  assign bp.bp_predict_o        = predict;
  assign bp.bp_taken_o          = predict[BP_CNT_BITS-1];
  assign bp.bp_history_o        = hist_q;
  assign bp.bp_mispredict_cnt_o = mp_cnt_q;

  // PC bits outside the index field are intentionally ignored.
  assign unused_pc_bits = ^{pc_sel, bp.ex_pc_i};
endmodule
